fb_reader: RTL and testbench
============================

# fb_reader

Wishbone master that reads the framebuffer in SDRAM in raster order and streams 24-bit pixels to the display side through an internal synchronous FIFO. It consumes the frame written by the test-pattern writer and sits between the SDRAM Wishbone slave and the video output stage. It is prefetch-driven: reads are issued whenever the FIFO has room, and a flush input resynchronises it to the frame start.

## Interface
Parameters:
- HDISP, 800, pixels per line
- VDISP, 480, lines per frame
- FIFO_DEPTH, 256, FIFO entries; power of two, ≥ 4

Ports:
- wshb_ifm.clk  in  1  clock, carried by the Wishbone interface
- wshb_ifm.rst  in  1  reset, synchronous, active-high, carried by the Wishbone interface
- wshb_ifm  master  wshb_if  Wishbone bus; uses adr/stb/cyc/we/sel/cti/bte/dat_ms out, dat_sm/ack in
- flush  in  1  synchronous frame resync
- pix_ready  in  1  consumer accepts the pixel
- pix_valid  out  1  FIFO not empty
- pix_data  out  24  pixel, {R,G,B} = dat_sm[23:0]
- pix_sof  out  1  pix_data is pixel (0,0) of a frame
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- underrun  out  1  sticky: pix_ready was seen while pix_valid=0

## Operation
- Counters: x_cnt is $clog2(HDISP) bits and y_cnt is $clog2(VDISP) bits.
  - On ack, x_cnt increments.
  - At x_cnt = HDISP-1, x_cnt wraps to 0 and y_cnt increments.
  - At y_cnt = VDISP-1 with x_cnt = HDISP-1, y_cnt wraps to 0.
- adr = (x_cnt + y_cnt*HDISP)*4, zero-extended to 32 bits.
- Fixed outputs: we=0, sel=4'b1111, cti=0, bte=0, dat_ms=0.
- Request: cyc = stb = (fifo_level < FIFO_DEPTH) && !flush && !rst.
  - At most one access is outstanding (Wishbone classic).
  - adr stays stable while stb=1 and ack=0.
- On ack with stb=1:
  - Push {sof, dat_sm[23:0]}, where sof = (x_cnt==0 && y_cnt==0).
  - Advance the counters.
- FIFO is first-word-fall-through:
  - pix_valid = (level ≠ 0).
  - pix_data and pix_sof show the head entry.
  - Pop when pix_valid && pix_ready.
  - Push and pop in the same cycle leave the level unchanged.
- Flush (registered action):
  - Level becomes 0 and the FIFO pointers reset.
  - x_cnt and y_cnt become 0; underrun clears.
  - An ack in the flush cycle is discarded and the counters do not advance.
  - A pop in the flush cycle is ignored.
- underrun sets on pix_ready && !pix_valid and holds until flush or reset.

## Timing
- Reset values: stb=cyc=0 while rst=1, adr=0, pix_valid=0, pix_sof=0, pix_data=don't-care, fifo_level=0, underrun=0.
- Latency: ack at edge N makes the word visible on pix_data with pix_valid=1 in the cycle after edge N.
- Back-pressure:
  - At level = FIFO_DEPTH-1, an ack without a simultaneous pop makes level = FIFO_DEPTH.
  - stb then drops the next cycle, with no overflow.
  - A pop in the full state re-raises stb the next cycle.
- Slave ack at 1 per cycle gives a throughput of 1 pixel/cycle.
- Frame wrap: the ack of pixel (HDISP-1, VDISP-1) makes adr=0 on the next cycle. The following pushed entry has sof=1.
- Reset mid-transfer: stb drops in the reset cycle, any ack is ignored, and all state returns to reset values after the edge.
- Flush and rst together behave as rst.

## Test plan
- Small params (HDISP=4, VDISP=3, FIFO_DEPTH=8), slave always acks, pix_ready=0 -> adr sequence 0,4,...,28; fifo_level reaches 8; stb=0 afterwards with adr=32 held.
- Same setup then pix_ready=1, slave returns dat_sm = index -> pix_data sequence 0,1,2,...; pix_sof=1 only on the index-0 pixel; steady state 1 pixel/cycle.
- Run 30 acks continuously -> adr wraps 44 -> 0 after the 12th ack; pix_sof=1 on pixels 0, 12, 24 only.
- Slave inserts 3 wait states per access -> stb and adr stable across the waits; exactly one push per ack; no duplicate or skipped address.
- Flush asserted mid-frame at adr=20 in the same cycle as an ack, with 5 entries held -> next cycle fifo_level=0, pix_valid=0, adr=0, underrun=0; the acked word never appears on pix_data.
- pix_ready=1 while the FIFO is empty -> underrun=1 and held through subsequent valid traffic; cleared only by flush or rst.

Source files
------------

// File: rtl/wshb_if.sv
// Wishbone bus bundle shared by the framebuffer masters and the SDRAM slave.
//
// Ports:
//   clk  - bus clock
//   rst  - synchronous active-high bus reset
//
// Signals: adr/dat_ms/we/sel/stb/cyc/cti/bte run master -> slave; dat_sm/ack run slave -> master.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk,
    input  rst,
    output adr,
    output dat_ms,
    output we,
    output cyc,
    output stb,
    output sel,
    output cti,
    output bte,
    input  dat_sm,
    input  ack
  );

  modport slave (
    input  clk,
    input  rst,
    input  adr,
    input  dat_ms,
    input  we,
    input  cyc,
    input  stb,
    input  sel,
    input  cti,
    input  bte,
    output dat_sm,
    output ack
  );

endinterface

// File: rtl/fb_reader.sv
// Framebuffer reader: Wishbone classic master that fetches the frame from SDRAM in raster order
// and streams 24-bit pixels to the display side through a first-word-fall-through FIFO.
// Reads are issued whenever the FIFO has room; flush resynchronises to the start of the frame.
//
// Ports:
//   wshb_ifm    - Wishbone master (clk, synchronous active-high rst carried by the bus)
//   flush       - synchronous frame resync: empties the FIFO, rewinds to pixel (0,0)
//   pix_ready   - consumer accepts the head pixel
//   pix_valid   - FIFO holds at least one pixel
//   pix_data    - head pixel {R,G,B}
//   pix_sof     - head pixel is pixel (0,0) of a frame
//   fifo_level  - current FIFO occupancy
//   underrun    - sticky: consumer was ready while the FIFO was empty
module fb_reader #(
  parameter int unsigned HDISP      = 800,
  parameter int unsigned VDISP      = 480,
  parameter int unsigned FIFO_DEPTH = 256
) (
  wshb_if.master                      wshb_ifm,
  input  logic                        flush,
  input  logic                        pix_ready,
  output logic                        pix_valid,
  output logic [23:0]                 pix_data,
  output logic                        pix_sof,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);

  localparam int unsigned XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int unsigned YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic clk;
  logic rst;

  assign clk = wshb_ifm.clk;
  assign rst = wshb_ifm.rst;

  // ---------------------------------------------------------------------------------------------
  // Raster position of the next word to fetch
  // ---------------------------------------------------------------------------------------------
  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic          x_last;
  logic          y_last;
  logic          frame_start;
  logic [31:0]   pix_idx;

  // ---------------------------------------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------------------------------------
  logic [24:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [24:0]   head;
  logic          underrun_q;

  logic          req;
  logic          push;
  logic          pop;

  assign x_last      = (x_cnt_q == XW'(HDISP - 1));
  assign y_last      = (y_cnt_q == YW'(VDISP - 1));
  assign frame_start = (x_cnt_q == '0) && (y_cnt_q == '0);

  // Linear pixel index; the constant multiplier reduces to shifts and adds.
  assign pix_idx = 32'(x_cnt_q) + 32'(y_cnt_q) * HDISP;

  // Request only while there is room. Gating with flush and rst keeps an ack landing in those
  // cycles from being treated as a completed transfer.
  assign req  = (level_q < LW'(FIFO_DEPTH)) && !flush && !rst;
  assign push = req && wshb_ifm.ack;
  assign pop  = pix_valid && pix_ready && !flush;

  // ---------------------------------------------------------------------------------------------
  // Wishbone outputs: single-beat classic reads, one outstanding access. The address is a pure
  // function of the counters, so it stays put until the ack advances them.
  // ---------------------------------------------------------------------------------------------
  assign wshb_ifm.cyc    = req;
  assign wshb_ifm.stb    = req;
  assign wshb_ifm.adr    = pix_idx << 2;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = 4'b1111;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.dat_ms = 32'h0;

  // Only the low 24 bits carry the pixel.
  logic unused_dat_hi;
  assign unused_dat_hi = ^wshb_ifm.dat_sm[31:24];

  // ---------------------------------------------------------------------------------------------
  // Counter next-state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (push) begin
      if (x_last) begin
        x_cnt_d = '0;
        y_cnt_d = y_last ? '0 : y_cnt_q + YW'(1);
      end else begin
        x_cnt_d = x_cnt_q + XW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // FIFO next-state
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // State registers; flush shares the reset path for everything except the storage array.
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      x_cnt_q    <= '0;
      y_cnt_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      x_cnt_q  <= x_cnt_d;
      y_cnt_q  <= y_cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (pix_ready && !pix_valid) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read once the level says they were written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {frame_start, wshb_ifm.dat_sm[23:0]};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stream outputs: head entry falls through combinationally.
  // ---------------------------------------------------------------------------------------------
  assign head       = mem[rd_ptr_q];
  assign pix_valid  = (level_q != '0);
  assign pix_data   = head[23:0];
  assign pix_sof    = pix_valid && head[24];
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_fb_reader.sv
module tb_fb_reader;

  localparam int unsigned H    = 4;
  localparam int unsigned V    = 3;
  localparam int unsigned D    = 8;
  localparam int unsigned NPIX = H * V;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        pix_ready;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_sof;
  logic [3:0]  fifo_level;
  logic        underrun;

  wshb_if wshb (.clk(clk), .rst(rst));

  fb_reader #(
    .HDISP(H),
    .VDISP(V),
    .FIFO_DEPTH(D)
  ) dut (
    .wshb_ifm  (wshb),
    .flush     (flush),
    .pix_ready (pix_ready),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .fifo_level(fifo_level),
    .underrun  (underrun)
  );

  int checks;
  int failures;

  // Reference model: contents of the pixel stream as a queue of {sof, rgb}, the raster index of
  // the next word to fetch and the sticky underrun flag.
  logic [24:0] q[$];
  int          exp_idx;
  bit          exp_under;

  // Slave behaviour knobs.
  int wait_states;
  bit rand_data;
  bit force_ack;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  // Wishbone slave: decides ack 1 time unit after each falling edge, after the main process has
  // set this cycle's inputs. Acks after wait_states idle cycles of a held request.
  initial begin
    int wcnt;
    wcnt        = 0;
    wshb.ack    = 1'b0;
    wshb.dat_sm = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (force_ack) begin
        wshb.ack    = 1'b1;
        wshb.dat_sm = $urandom;
        wcnt        = 0;
      end else if (wshb.stb && wshb.cyc) begin
        if (wcnt >= wait_states) begin
          wshb.ack    = 1'b1;
          wshb.dat_sm = {8'($urandom), rand_data ? 24'($urandom) : 24'(wshb.adr >> 2)};
          wcnt        = 0;
        end else begin
          wshb.ack = 1'b0;
          wcnt++;
        end
      end else begin
        wshb.ack = 1'b0;
        wcnt     = 0;
      end
    end
  end

  function automatic bit model_stb();
    return (q.size() < D) && !flush && !rst;
  endfunction

  // Applies the behavioural rules for the current cycle's inputs, then moves to the next
  // falling edge.
  task automatic advance();
    bit do_push;
    bit do_pop;
    do_push = model_stb() && wshb.ack;
    do_pop  = (q.size() != 0) && pix_ready && !flush && !rst;
    if (rst || flush) begin
      q.delete();
      exp_idx   = 0;
      exp_under = 1'b0;
    end else begin
      if (pix_ready && q.size() == 0) exp_under = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back({exp_idx == 0, wshb.dat_sm[23:0]});
        exp_idx = (exp_idx + 1) % NPIX;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      #2;
      checks++;
      if (wshb.stb !== 1'b0 || wshb.cyc !== 1'b0) begin
        failures++;
        $display("FAIL reset_stb: stb=%b cyc=%b required 0", wshb.stb, wshb.cyc);
      end
      advance();
    end
    rst = 1'b0;
    flush = 1'b0;
    #2;
    checks++;
    if (wshb.adr !== 32'h0) begin
      failures++;
      $display("FAIL reset_adr: got %0h required 0", wshb.adr);
    end
    checks++;
    if (pix_valid !== 1'b0 || pix_sof !== 1'b0 || fifo_level !== 4'd0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b sof=%b level=%0d underrun=%b required 0", pix_valid,
               pix_sof, fifo_level, underrun);
    end
    checks++;
    if (wshb.we !== 1'b0 || wshb.sel !== 4'hf || wshb.cti !== 3'd0 || wshb.bte !== 2'd0 ||
        wshb.dat_ms !== 32'h0) begin
      failures++;
      $display("FAIL fixed_outputs: we=%b sel=%h cti=%0d bte=%0d dat_ms=%h", wshb.we, wshb.sel,
               wshb.cti, wshb.bte, wshb.dat_ms);
    end
    checks++;
    if (wshb.stb !== model_stb()) begin
      failures++;
      $display("FAIL stb_after_reset: got %b required %b", wshb.stb, model_stb());
    end
    advance();
  endtask

  task automatic test_fill();
    pix_ready = 1'b0;
    wait_states = 0;
    rand_data = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #2;
      checks++;
      if (wshb.stb !== model_stb() || wshb.cyc !== model_stb()) begin
        failures++;
        $display("FAIL fill_stb: cycle %0d stb=%b cyc=%b required %b", i, wshb.stb, wshb.cyc,
                 model_stb());
      end
      checks++;
      if (wshb.adr !== 32'(exp_idx * 4)) begin
        failures++;
        $display("FAIL fill_adr: cycle %0d got %0d required %0d", i, wshb.adr, exp_idx * 4);
      end
      checks++;
      if (fifo_level !== 4'(q.size())) begin
        failures++;
        $display("FAIL fill_level: cycle %0d got %0d required %0d", i, fifo_level, q.size());
      end
      advance();
    end
    #2;
    checks++;
    if (fifo_level !== 4'd8 || wshb.stb !== 1'b0 || wshb.adr !== 32'd32) begin
      failures++;
      $display("FAIL fill_full: level=%0d stb=%b adr=%0d required 8/0/32", fifo_level, wshb.stb,
               wshb.adr);
    end
    advance();
  endtask

  task automatic test_drain();
    int served;
    served = 0;
    pix_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #2;
      checks++;
      if (pix_valid !== (q.size() != 0)) begin
        failures++;
        $display("FAIL drain_valid: cycle %0d got %b required %b", i, pix_valid, q.size() != 0);
      end
      if (q.size() != 0) begin
        checks++;
        if (pix_data !== q[0][23:0] || pix_sof !== q[0][24]) begin
          failures++;
          $display("FAIL drain_data: cycle %0d data=%0d sof=%b required %0d/%b", i, pix_data,
                   pix_sof, q[0][23:0], q[0][24]);
        end
      end
      checks++;
      if (wshb.adr !== 32'(exp_idx * 4) || wshb.stb !== model_stb()) begin
        failures++;
        $display("FAIL drain_bus: cycle %0d adr=%0d stb=%b required %0d/%b", i, wshb.adr,
                 wshb.stb, exp_idx * 4, model_stb());
      end
      if (i >= 10 && pix_valid && pix_ready) served++;
      advance();
    end
    checks++;
    if (served != 30 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL drain_throughput: %0d pixels in 30 cycles underrun=%b required 30/0",
               served, underrun);
    end
  endtask

  task automatic test_wait_states();
    wait_states = 3;
    rand_data = 1'b1;
    for (int i = 0; i < 80; i++) begin
      pix_ready = 1'($urandom_range(0, 1));
      #2;
      checks++;
      if (wshb.stb !== model_stb() || wshb.adr !== 32'(exp_idx * 4)) begin
        failures++;
        $display("FAIL wait_bus: cycle %0d stb=%b adr=%0d required %b/%0d", i, wshb.stb,
                 wshb.adr, model_stb(), exp_idx * 4);
      end
      checks++;
      if (fifo_level !== 4'(q.size()) || underrun !== exp_under) begin
        failures++;
        $display("FAIL wait_level: cycle %0d level=%0d underrun=%b required %0d/%b", i,
                 fifo_level, underrun, q.size(), exp_under);
      end
      if (q.size() != 0) begin
        checks++;
        if (pix_data !== q[0][23:0] || pix_sof !== q[0][24]) begin
          failures++;
          $display("FAIL wait_data: cycle %0d data=%h sof=%b required %h/%b", i, pix_data,
                   pix_sof, q[0][23:0], q[0][24]);
        end
      end
      advance();
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_flush_mid_frame();
    wait_states = 0;
    rand_data = 1'b1;
    pix_ready = 1'b0;
    flush = 1'b1;
    #2;
    advance();
    flush = 1'b0;
    for (int i = 0; i < 20 && exp_idx != 5; i++) begin
      #2;
      advance();
    end
    #2;
    checks++;
    if (wshb.adr !== 32'd20 || fifo_level !== 4'd5) begin
      failures++;
      $display("FAIL flush_setup: adr=%0d level=%0d required 20/5", wshb.adr, fifo_level);
    end
    // Flush lands with an ack and a pop request in the same cycle.
    flush = 1'b1;
    force_ack = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (wshb.stb !== 1'b0) begin
      failures++;
      $display("FAIL flush_stb: got %b required 0", wshb.stb);
    end
    advance();
    flush = 1'b0;
    force_ack = 1'b0;
    pix_ready = 1'b0;
    #2;
    checks++;
    if (fifo_level !== 4'd0 || pix_valid !== 1'b0 || wshb.adr !== 32'd0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL flush_state: level=%0d valid=%b adr=%0d underrun=%b required 0", fifo_level,
               pix_valid, wshb.adr, underrun);
    end
    advance();
    pix_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (q.size() != 0) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_data !== q[0][23:0] || pix_sof !== q[0][24]) begin
          failures++;
          $display("FAIL flush_stream: cycle %0d valid=%b data=%h sof=%b required 1/%h/%b", i,
                   pix_valid, pix_data, pix_sof, q[0][23:0], q[0][24]);
        end
      end
      advance();
    end
    pix_ready = 1'b0;
  endtask

  task automatic test_underrun();
    wait_states = 2;
    pix_ready = 1'b0;
    flush = 1'b1;
    #2;
    advance();
    flush = 1'b0;
    pix_ready = 1'b1;
    #2;
    checks++;
    if (pix_valid !== 1'b0 || underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_pre: valid=%b underrun=%b required 0/0", pix_valid, underrun);
    end
    advance();
    for (int i = 0; i < 30; i++) begin
      pix_ready = 1'($urandom_range(0, 1));
      #2;
      checks++;
      if (underrun !== 1'b1) begin
        failures++;
        $display("FAIL underrun_hold: cycle %0d got %b required 1", i, underrun);
      end
      if (q.size() != 0) begin
        checks++;
        if (pix_data !== q[0][23:0] || pix_sof !== q[0][24]) begin
          failures++;
          $display("FAIL underrun_data: cycle %0d data=%h required %h", i, pix_data, q[0][23:0]);
        end
      end
      advance();
    end
    pix_ready = 1'b0;
    flush = 1'b1;
    #2;
    advance();
    flush = 1'b0;
    pix_ready = 1'b1;
    #2;
    checks++;
    if (underrun !== 1'b0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL underrun_flush_clear: underrun=%b valid=%b required 0/0", underrun,
               pix_valid);
    end
    advance();
    pix_ready = 1'b0;
    rst = 1'b1;
    #2;
    checks++;
    if (underrun !== 1'b1) begin
      failures++;
      $display("FAIL underrun_reset_pre: got %b required 1", underrun);
    end
    advance();
    rst = 1'b0;
    #2;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_reset_clear: got %b required 0", underrun);
    end
    advance();
  endtask

  task automatic test_reset_mid();
    wait_states = 0;
    for (int i = 0; i < 6; i++) begin
      pix_ready = 1'($urandom_range(0, 1));
      #2;
      advance();
    end
    rst = 1'b1;
    flush = 1'b1;
    force_ack = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    #2;
    checks++;
    if (wshb.stb !== 1'b0 || wshb.cyc !== 1'b0) begin
      failures++;
      $display("FAIL midreset_stb: stb=%b cyc=%b required 0", wshb.stb, wshb.cyc);
    end
    advance();
    rst = 1'b0;
    flush = 1'b0;
    force_ack = 1'b0;
    pix_ready = 1'b0;
    #2;
    checks++;
    if (fifo_level !== 4'd0 || pix_valid !== 1'b0 || pix_sof !== 1'b0 || wshb.adr !== 32'd0 ||
        underrun !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state: level=%0d valid=%b sof=%b adr=%0d underrun=%b required 0",
               fifo_level, pix_valid, pix_sof, wshb.adr, underrun);
    end
    advance();
  endtask

  task automatic test_random();
    rand_data = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (i % 20 == 0) wait_states = $urandom_range(0, 2);
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      pix_ready = ($urandom_range(0, 3) != 0);
      #2;
      checks++;
      if (wshb.stb !== model_stb() || wshb.adr !== 32'(exp_idx * 4)) begin
        failures++;
        $display("FAIL rand_bus: cycle %0d stb=%b adr=%0d required %b/%0d", i, wshb.stb,
                 wshb.adr, model_stb(), exp_idx * 4);
      end
      checks++;
      if (fifo_level !== 4'(q.size()) || pix_valid !== (q.size() != 0) ||
          underrun !== exp_under) begin
        failures++;
        $display("FAIL rand_state: cycle %0d level=%0d valid=%b underrun=%b required %0d/%b/%b",
                 i, fifo_level, pix_valid, underrun, q.size(), q.size() != 0, exp_under);
      end
      if (q.size() != 0) begin
        checks++;
        if (pix_data !== q[0][23:0] || pix_sof !== q[0][24]) begin
          failures++;
          $display("FAIL rand_data: cycle %0d data=%h sof=%b required %h/%b", i, pix_data,
                   pix_sof, q[0][23:0], q[0][24]);
        end
      end else begin
        checks++;
        if (pix_sof !== 1'b0) begin
          failures++;
          $display("FAIL rand_sof_empty: cycle %0d got %b required 0", i, pix_sof);
        end
      end
      advance();
    end
    rst = 1'b0;
    flush = 1'b0;
    pix_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_idx = 0;
    exp_under = 1'b0;
    wait_states = 0;
    rand_data = 1'b0;
    force_ack = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    pix_ready = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_wait_states();
    test_flush_mid_frame();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
